// File: rtl/snes_pkg.sv
// Shared constants and FSM state type for the save-RAM serial dumper.
package snes_pkg;

  localparam int unsigned HDR_LEN = 32;

  localparam logic [7:0] MAGIC [4] = '{8'h53, 8'h52, 8'h41, 8'h4D};

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD_REQ,
    S_RD_WAIT,
    S_SEND,
    S_FIN
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first, each bit held DIV cycles.
module uart_tx_byte #(
  parameter int unsigned DIV = 93
) (
  input  logic       wclk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic          active;
  logic [CW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          last_cycle;

  // Ready also in the final stop-bit cycle so a queued byte starts with no idle gap.
  assign last_cycle = active && (div_cnt == CW'(DIV - 1)) && (bit_cnt == 4'd9);
  assign ready      = !active || last_cycle;
  assign tx         = active ? shreg[0] : 1'b1;

  always_ff @(posedge wclk) begin
    if (reset) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
    end else if (send && ready) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= {1'b1, data, 1'b0};
    end else if (active) begin
      if (div_cnt == CW'(DIV - 1)) begin
        div_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_dumper.sv
// Streams a 32-byte header followed by save RAM contents over a UART.
module sram_dumper
  import snes_pkg::*;
#(
  parameter int unsigned FREQ = 10_800_000,
  parameter int unsigned BAUD = 115200
) (
  input  logic        wclk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  map_ctrl,
  input  logic [7:0]  rom_type_header,
  input  logic [3:0]  rom_size,
  input  logic [3:0]  ram_size,
  input  logic [23:0] ram_mask,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rvalid,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DIV = FREQ / BAUD;

  state_t      state, state_nx;
  logic [5:0]  hdr_idx;
  logic [23:0] idx, len;
  logic [24:0] idx_inc;
  logic [7:0]  map_q, type_q, rd_q;
  logic [3:0]  rom_q, ram_q;
  logic        sent, send, ready;
  logic [7:0]  hdr_byte, tx_data;

  assign idx_inc  = {1'b0, idx} + 25'd1;
  assign mem_addr = idx;
  assign busy     = (state != S_IDLE) && (state != S_FIN);
  assign tx_data  = (state == S_HDR) ? hdr_byte : rd_q;

  always_comb begin
    hdr_byte = '0;
    case (hdr_idx)
      6'd0:    hdr_byte = MAGIC[0];
      6'd1:    hdr_byte = MAGIC[1];
      6'd2:    hdr_byte = MAGIC[2];
      6'd3:    hdr_byte = MAGIC[3];
      6'd4:    hdr_byte = map_q;
      6'd5:    hdr_byte = type_q;
      6'd6:    hdr_byte = {4'b0, rom_q};
      6'd7:    hdr_byte = {4'b0, ram_q};
      6'd8:    hdr_byte = len[7:0];
      6'd9:    hdr_byte = len[15:8];
      6'd10:   hdr_byte = len[23:16];
      default: hdr_byte = '0;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    send     = 1'b0;
    mem_rd   = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_HDR;
      // hdr_idx==32 with ready asserted means byte 31 is in its last stop cycle.
      S_HDR: if (ready) begin
        if (hdr_idx == 6'(HDR_LEN)) state_nx = (len != '0) ? S_RD_REQ : S_FIN;
        else                        send     = 1'b1;
      end
      S_RD_REQ: begin
        mem_rd   = 1'b1;
        state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: if (mem_rvalid) state_nx = S_SEND;
      S_SEND: if (ready) begin
        if (!sent) send = 1'b1;
        else       state_nx = (idx_inc < {1'b0, len}) ? S_RD_REQ : S_FIN;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (reset) begin
      hdr_idx <= '0;
      idx     <= '0;
      len     <= '0;
      map_q   <= '0;
      type_q  <= '0;
      rom_q   <= '0;
      ram_q   <= '0;
      rd_q    <= '0;
      sent    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          map_q   <= map_ctrl;
          type_q  <= rom_type_header;
          rom_q   <= rom_size;
          ram_q   <= ram_size;
          len     <= (ram_size == 4'd0) ? '0 : (&ram_mask) ? '1 : ram_mask + 24'd1;
          hdr_idx <= '0;
          idx     <= '0;
          sent    <= 1'b0;
        end
        S_HDR:     if (send) hdr_idx <= hdr_idx + 6'd1;
        S_RD_REQ:  sent <= 1'b0;
        S_RD_WAIT: if (mem_rvalid) rd_q <= mem_rdata;
        S_SEND: begin
          if (send)               sent <= 1'b1;
          else if (ready && sent) idx  <= idx + 24'd1;
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .wclk  (wclk),
    .reset (reset),
    .data  (tx_data),
    .send  (send),
    .tx    (uart_tx),
    .ready (ready)
  );

endmodule

// File: tb/tb_sram_dumper.sv
// Self-checking bench: line-level byte model with per-cycle bit checks, gaps and done timing.
module tb_sram_dumper;

  localparam int unsigned DIV = 4;
  localparam int          LAT = 3;

  logic        wclk = 1'b0;
  logic        reset, start;
  logic [7:0]  map_ctrl, rom_type_header;
  logic [3:0]  rom_size, ram_size;
  logic [23:0] ram_mask, mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid, uart_tx, busy, done;

  always #5 wclk = ~wclk;

  sram_dumper #(.FREQ(40), .BAUD(10)) dut (
    .wclk            (wclk),
    .reset           (reset),
    .start           (start),
    .map_ctrl        (map_ctrl),
    .rom_type_header (rom_type_header),
    .rom_size        (rom_size),
    .ram_size        (ram_size),
    .ram_mask        (ram_mask),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_rdata       (mem_rdata),
    .mem_rvalid      (mem_rvalid),
    .uart_tx         (uart_tx),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    logic [7:0] b;
    int         gap;
    bit         last;
  } exp_t;

  int          tests = 0, fails = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [7:0]  rx_log[$];
  bit          in_frame = 0, done_due = 0, inject = 0;
  int          frm_pos = 0, n_frames = 0, frame0_cyc = 0;
  logic [9:0]  first_pat = '0;
  logic [23:0] exp_addr = '0;
  int          exp_rd_left = 0;

  always @(posedge wclk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Compare process: receives frames on the line and checks them against the expected byte queue.
  initial begin
    exp_t       cur;
    bit         frame_ok;
    logic [7:0] rxb;
    logic [9:0] pat;
    int         gap, k;
    logic       lvl;
    cur = '{8'h00, -1, 1'b0};
    frame_ok = 1; rxb = '0; pat = '0; gap = 0;
    forever begin
      @(negedge wclk);
      if (reset) begin
        in_frame = 0; done_due = 0; exp_q.delete(); gap = 0;
        continue;
      end
      if (done || done_due) begin
        chk(done == done_due && !busy, "done_pulse", {30'd0, done, busy}, {30'd0, done_due, 1'b0});
        done_due = 0;
      end
      if (mem_rd) begin
        chk(exp_rd_left > 0 && mem_addr == exp_addr, "mem_rd_addr", mem_addr, exp_addr);
        exp_addr++;
        exp_rd_left--;
      end
      if (!in_frame) begin
        if (uart_tx == 1'b0) begin
          if (exp_q.size() == 0) begin
            chk(0, "unexpected_frame", 32'd1, 32'd0);
            cur = '{8'h00, -1, 1'b0};
          end else begin
            cur = exp_q.pop_front();
            if (cur.gap >= 0) chk(gap == cur.gap, "idle_gap", gap, cur.gap);
          end
          if (n_frames == 0) frame0_cyc = cyc;
          in_frame = 1; frm_pos = 0; frame_ok = 1; rxb = '0; pat = '0;
        end else begin
          gap++;
        end
      end
      if (in_frame) begin
        k = frm_pos / DIV;
        lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : cur.b[k-1];
        if (uart_tx !== lvl) frame_ok = 0;
        if (frm_pos % DIV == DIV / 2) begin
          pat[k] = uart_tx;
          if (k >= 1 && k <= 8) rxb[k-1] = uart_tx;
        end
        frm_pos++;
        if (frm_pos == 10 * DIV) begin
          in_frame = 0;
          gap = 0;
          chk(frame_ok && rxb == cur.b, "rx_byte", {24'd0, rxb}, {24'd0, cur.b});
          rx_log.push_back(rxb);
          if (n_frames == 0) first_pat = pat;
          n_frames++;
          if (cur.last) done_due = 1;
        end
      end
    end
  end

  // Memory model: data = addr[7:0] after LAT cycles; optional stray rvalid pulses mid-frame.
  initial begin
    bit          pend;
    int          cnt;
    logic [23:0] paddr;
    pend = 0; cnt = 0; paddr = '0;
    mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge wclk);
      mem_rvalid = 0;
      if (reset) begin
        pend = 0;
        continue;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1; mem_rdata = paddr[7:0]; pend = 0;
        end
      end else if (mem_rd) begin
        pend = 1; cnt = LAT; paddr = mem_addr;
      end else if (inject && in_frame && frm_pos > 1 && frm_pos < 10 * DIV - 2 &&
                   $urandom_range(0, 5) == 0) begin
        mem_rvalid = 1; mem_rdata = 8'hEE;
      end
    end
  end

  task automatic load(input logic [7:0] m, input logic [7:0] t, input logic [3:0] rs,
                      input logic [3:0] rz, input logic [23:0] mask, input int npay);
    logic [23:0] len;
    logic [7:0]  mg [4];
    logic [7:0]  b;
    mg = '{8'h53, 8'h52, 8'h41, 8'h4D};
    len = (rz == 4'd0) ? 24'd0 : (mask == 24'hFFFFFF) ? 24'hFFFFFF : mask + 24'd1;
    map_ctrl = m; rom_type_header = t; rom_size = rs; ram_size = rz; ram_mask = mask;
    exp_q.delete(); rx_log.delete(); n_frames = 0;
    exp_addr = '0; exp_rd_left = int'(len);
    for (int i = 0; i < 32; i++) begin
      if (i < 4)        b = mg[i];
      else if (i == 4)  b = m;
      else if (i == 5)  b = t;
      else if (i == 6)  b = {4'b0, rs};
      else if (i == 7)  b = {4'b0, rz};
      else if (i == 8)  b = len[7:0];
      else if (i == 9)  b = len[15:8];
      else if (i == 10) b = len[23:16];
      else              b = 8'h00;
      exp_q.push_back('{b, (i == 0) ? -1 : 0, (len == 0 && i == 31)});
    end
    for (int p = 0; p < npay; p++)
      exp_q.push_back('{p[7:0], (p == 0) ? -1 : 2 + LAT, (p == npay - 1 && p == int'(len) - 1)});
  endtask

  task automatic start_pulse(output int t0);
    start = 1; t0 = cyc;
    @(negedge wclk);
    start = 0;
    chk(busy == 1'b1, "busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge wclk);
      if (done) begin ok = 1; break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0;
    bit          ok;
    logic [7:0]  lit [5];
    reset = 1; start = 0; map_ctrl = '0; rom_type_header = '0;
    rom_size = '0; ram_size = '0; ram_mask = '0;
    repeat (3) @(negedge wclk);
    reset = 0;
    @(negedge wclk);
    chk({uart_tx, busy, done, mem_rd} == 4'b1000, "reset_outputs",
        {28'd0, uart_tx, busy, done, mem_rd}, 32'h8);
    chk(mem_addr == 24'd0, "reset_addr", mem_addr, 32'd0);

    // Header only; extra starts while busy and coincident with done.
    load(8'h21, 8'h35, 4'h9, 4'h0, 24'h0, 0);
    start_pulse(t0);
    repeat (50 * DIV) @(negedge wclk);
    start = 1; @(negedge wclk); start = 0;
    wait_done(32 * 10 * DIV + 100, ok);
    chk(ok, "done_t1", {31'd0, ok}, 32'd1);
    start = 1; @(negedge wclk); start = 0;
    repeat (30 * DIV) @(negedge wclk);
    chk(busy == 1'b0, "idle_after_done", {31'd0, busy}, 32'd0);
    chk(rx_log.size() == 32, "t1_len", rx_log.size(), 32);
    lit = '{8'h53, 8'h52, 8'h41, 8'h4D, 8'h21};
    for (int i = 0; i < 5 && i < rx_log.size(); i++)
      chk(rx_log[i] == lit[i], "t1_hdr_lit", rx_log[i], lit[i]);
    if (rx_log.size() == 32) begin
      chk(rx_log[8] == 8'h00 && rx_log[31] == 8'h00, "t1_zero_tail", {rx_log[8], rx_log[31]}, 32'd0);
    end
    chk(first_pat == 10'b1010100110, "bit_pattern_53", first_pat, 10'b1010100110);
    chk(frame0_cyc - t0 >= 1 && frame0_cyc - t0 <= 2, "first_start_bit", frame0_cyc - t0, 2);
    chk(exp_rd_left == 0, "t1_no_reads", exp_rd_left, 0);

    // 512-byte payload with stray rvalid pulses.
    load(8'h20, 8'h02, 4'h8, 4'h1, 24'h1FF, 512);
    inject = 1;
    start_pulse(t0);
    wait_done(30000, ok);
    inject = 0;
    chk(ok, "done_t2", {31'd0, ok}, 32'd1);
    @(negedge wclk);
    chk(rx_log.size() == 544, "t2_len", rx_log.size(), 544);
    if (rx_log.size() == 544) begin
      chk({rx_log[8], rx_log[9], rx_log[10]} == 24'h000200, "t2_len_field",
          {rx_log[8], rx_log[9], rx_log[10]}, 24'h000200);
      chk(rx_log[332] == 8'h2C, "t2_payload_300", rx_log[332], 8'h2C);
      chk(rx_log[543] == 8'hFF, "t2_payload_last", rx_log[543], 8'hFF);
    end
    chk(exp_rd_left == 0, "t2_all_reads", exp_rd_left, 0);

    // Clamped length, then reset in the middle of a payload bit.
    load(8'h31, 8'h01, 4'hC, 4'h2, 24'hFFFFFF, 3);
    start_pulse(t0);
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge wclk);
      if (rx_log.size() >= 34 && in_frame && frm_pos == 5 * DIV + 1) begin ok = 1; break; end
    end
    chk(ok, "t3_reach_payload", {31'd0, ok}, 32'd1);
    reset = 1;
    @(negedge wclk);
    chk(uart_tx == 1'b1 && busy == 1'b0, "reset_abort", {30'd0, uart_tx, busy}, 32'h2);
    @(negedge wclk);
    reset = 0;
    if (rx_log.size() >= 11) begin
      chk({rx_log[8], rx_log[9], rx_log[10]} == 24'hFFFFFF, "t3_clamp",
          {rx_log[8], rx_log[9], rx_log[10]}, 24'hFFFFFF);
    end

    // Fresh dump after reset starts from header byte 0.
    load(8'h31, 8'h00, 4'h7, 4'h0, 24'h0, 0);
    start_pulse(t0);
    wait_done(32 * 10 * DIV + 100, ok);
    chk(ok, "done_t4", {31'd0, ok}, 32'd1);
    @(negedge wclk);
    chk(rx_log.size() == 32, "t4_len", rx_log.size(), 32);
    if (rx_log.size() == 32) begin
      chk(rx_log[0] == 8'h53 && rx_log[4] == 8'h31, "t4_hdr", {rx_log[0], rx_log[4]}, 16'h5331);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_dumper.md
# sram_dumper

Streams the cartridge save RAM (BSRAM) back to the host over a UART, in the same framing the loader's serial input accepts: a 32-byte header, then payload bytes. It sits beside the loader on `wclk`. It reads save RAM through a simple request/valid memory port and drives a single 8N1 TX line. It is triggered by a one-cycle `start` pulse from the menu or debug logic.

## Interface
- `FREQ`, default 10_800_000: `wclk` frequency in Hz.
- `BAUD`, default 115200: UART bit rate. Bit period is `DIV = FREQ/BAUD` cycles, integer-truncated (93 at defaults).
- `wclk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; begins a dump. Ignored while `busy`.
- `map_ctrl`  in  8  SNES header byte 0x15.
- `rom_type_header`  in  8  SNES header byte 0x16.
- `rom_size`  in  4  ROM size code.
- `ram_size`  in  4  RAM size code; 0 means no save RAM.
- `ram_mask`  in  24  save RAM address mask; payload length is `ram_mask+1`.
- `mem_addr`  out  24  save RAM byte address.
- `mem_rd`  out  1  one-cycle read request.
- `mem_rdata`  in  8  read data.
- `mem_rvalid`  in  1  pulse; `mem_rdata` is valid this cycle.
- `uart_tx`  out  1  serial line; idles high.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last stop bit.

## Operation
- Reset values: `uart_tx`=1, `busy`=0, `done`=0, `mem_rd`=0, `mem_addr`=0. Reset mid-frame aborts immediately; `uart_tx` is 1 on the cycle after reset is sampled.
- On an accepted `start`, capture all header inputs and compute `len`:
  - `len` = 0 if `ram_size==0`.
  - Otherwise `len` = `ram_mask+1`, 25 bits wide. Payload length is 24 bits, so `ram_mask=24'hFFFFFF` is clamped to 24'hFFFFFF bytes.
- Header byte order:
  - 0–3: ASCII "SRAM" (0x53 0x52 0x41 0x4D).
  - 4: `map_ctrl`.
  - 5: `rom_type_header`.
  - 6: {4'b0, `rom_size`}.
  - 7: {4'b0, `ram_size`}.
  - 8–10: `len`, little-endian.
  - 11–31: 0x00.
- State machine:
  - IDLE: wait for `start`.
  - HDR: send header bytes 0..31 in order. After byte 31, go to RD_REQ if `len`≠0, else FIN.
  - RD_REQ: assert `mem_rd` for one cycle with `mem_addr`=current index. Go to RD_WAIT.
  - RD_WAIT: on `mem_rvalid`, latch `mem_rdata` and go to SEND.
  - SEND: transmit the latched byte. When the transmitter is idle, increment the index. Go to RD_REQ if index<`len`, else FIN.
  - FIN: pulse `done`, clear `busy`, return to IDLE.
- The memory read for byte n+1 is issued only after byte n has completed its stop bit. The read is not overlapped with transmission.
- `mem_rvalid` outside RD_WAIT is ignored.
- The index counter is 24 bits and does not wrap within a dump.
- UART framing: 8N1, LSB first. Start bit is 0, stop bit is 1. Each bit is held exactly `DIV` cycles.

## Timing
- Accepted `start` at cycle T: `busy`=1 at T+1; start bit of header byte 0 begins no later than T+2.
- Each byte takes exactly 10·`DIV` cycles.
- Back-to-back header bytes have no idle gap; the next start bit follows the stop bit directly.
- Payload inter-byte gap = 2 cycles + memory read latency.
- `done` is asserted the cycle after the final stop bit's last cycle; `busy` falls in that same cycle.
- A `start` coincident with `done` is ignored.

## Structure
- Shared package `snes_pkg` holds:
  - the header length constant (32);
  - the magic bytes;
  - the state enum.
- Sub-module `uart_tx_byte` (param `DIV`), ports:
  - `wclk`, `reset`;
  - `data[7:0]`, `send` (pulse);
  - `tx`, `ready`.
- `ready` is high when idle. `send` is honoured only when `ready`=1.
- The top level holds the FSM, the header mux, the index/length counters and the memory handshake.

## Test plan
- `ram_size`=0, `map_ctrl`=0x21, `start` → exactly 32 bytes sent: 53 52 41 4D 21 xx xx 00 00 00 00 then 21×00, followed by a `done` pulse. `mem_rd` is never asserted.
- `ram_size`=3, `ram_mask`=0x1FFF, memory returns `addr[7:0]` with 3-cycle latency:
  - header bytes 8–10 = 00 20 00;
  - 8192 payload bytes are 00,01,…,FF repeating;
  - `done` follows.
- Bit timing at defaults: every bit of byte 0x53 lasts 93 cycles. Line pattern is 0,1,1,0,0,1,0,1,0,1.
- `start` pulsed again while `busy`, and again coincident with `done` → no second frame and no change to the byte stream.
- `reset` asserted mid-payload bit → `uart_tx`=1 and `busy`=0 next cycle. A fresh `start` then produces a complete header from byte 0.
- `mem_rvalid` pulses injected during HDR and during SEND → ignored; payload bytes are unchanged.
